// File: rtl/lm07_temp_display_ctrl.sv
// lm07_temp_display_ctrl
// Converts each latched signed 8-bit Celsius sample into sign plus three BCD
// digits with an iterative double-dabble engine, then drives a time-multiplexed
// 3-digit common 7-segment bus with leading-zero blanking.

module lm07_temp_display_ctrl #(
  parameter int unsigned REFRESH_DIV    = 1024,
  parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] temp_in,
  input  logic       temp_valid,
  output logic       busy,
  output logic [7:0] seg,
  output logic [2:0] dig_en
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_CONV   = 2'd2,
    S_UPDATE = 2'd3
  } state_t;

  // Output polarity mask and the reset image of the output registers.
  localparam logic [7:0] SEG_MASK  = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [2:0] DIG_MASK  = SEG_ACTIVE_LOW ? 3'b111 : 3'b000;
  localparam logic [7:0] SEG_RST   = 8'h3F ^ SEG_MASK;
  localparam logic [2:0] DIG_RST   = 3'b001 ^ DIG_MASK;
  localparam logic [15:0] DIV_LAST = 16'(REFRESH_DIV - 1);

  // Conversion FSM state
  state_t      r_state;
  logic        r_busy;
  logic [7:0]  r_sample;
  logic [7:0]  r_pend_val;
  logic        r_pend_full;
  logic        r_sign;
  logic [7:0]  r_mag;
  logic [11:0] r_bcd;
  logic [2:0]  r_iter;

  // Display registers: only written in UPDATE
  logic        r_disp_sign;
  logic [11:0] r_disp_bcd;

  // Scan state
  logic [15:0] r_div;
  logic [1:0]  r_scan_idx;
  logic [7:0]  r_seg;
  logic [2:0]  r_dig_en;

  // Combinational helpers
  logic        w_neg;
  logic [7:0]  w_abs;
  logic [7:0]  w_mag_load;
  logic [11:0] w_bcd_adj;
  logic [19:0] w_cat;
  logic        w_dsign_next;
  logic [11:0] w_dbcd_next;
  logic [1:0]  w_idx_next;
  logic [7:0]  w_seg_next;

  genvar gi;

  // Sign and clamped magnitude of the latched sample; -128..-100 show as -99.
  assign w_neg      = r_sample[7];
  assign w_abs      = w_neg ? (~r_sample + 8'd1) : r_sample;
  assign w_mag_load = (w_neg && (w_abs > 8'd99)) ? 8'd99 : w_abs;

  // Double-dabble add-3 correction on every BCD nibble before the shift.
  generate
    for (gi = 0; gi < 3; gi++) begin : g_adj
      assign w_bcd_adj[gi*4 +: 4] = (r_bcd[gi*4 +: 4] >= 4'd5)
                                    ? (r_bcd[gi*4 +: 4] + 4'd3)
                                    : r_bcd[gi*4 +: 4];
    end
  endgenerate

  assign w_cat = {w_bcd_adj, r_mag} << 1;

  // Display values as they will be after this edge, so seg tracks UPDATE
  // with no extra cycle of delay.
  assign w_dsign_next = (r_state == S_UPDATE) ? r_sign : r_disp_sign;
  assign w_dbcd_next  = (r_state == S_UPDATE) ? r_bcd  : r_disp_bcd;

  assign w_idx_next = (r_div == DIV_LAST)
                      ? ((r_scan_idx == 2'd2) ? 2'd0 : (r_scan_idx + 2'd1))
                      : r_scan_idx;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'h3F;
      4'd1:    seg7 = 8'h06;
      4'd2:    seg7 = 8'h5B;
      4'd3:    seg7 = 8'h4F;
      4'd4:    seg7 = 8'h66;
      4'd5:    seg7 = 8'h6D;
      4'd6:    seg7 = 8'h7D;
      4'd7:    seg7 = 8'h07;
      4'd8:    seg7 = 8'h7F;
      4'd9:    seg7 = 8'h6F;
      default: seg7 = 8'h00;
    endcase
  endfunction

  // Select the segment pattern for the digit that will be enabled next.
  always_comb begin
    w_seg_next = 8'h00;
    case (w_idx_next)
      2'd0: w_seg_next = seg7(w_dbcd_next[3:0]);
      2'd1: w_seg_next = (w_dbcd_next[11:4] == 8'h00) ? 8'h00
                                                      : seg7(w_dbcd_next[7:4]);
      2'd2: begin
        if (w_dsign_next)
          w_seg_next = 8'h40;
        else if (w_dbcd_next[11:8] != 4'd0)
          w_seg_next = seg7(w_dbcd_next[11:8]);
        else
          w_seg_next = 8'h00;
      end
      default: w_seg_next = 8'h00;
    endcase
  end

  // Conversion FSM with pending buffer and registered busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_sample    <= 8'h00;
      r_pend_val  <= 8'h00;
      r_pend_full <= 1'b0;
      r_sign      <= 1'b0;
      r_mag       <= 8'h00;
      r_bcd       <= 12'h000;
      r_iter      <= 3'd0;
      r_disp_sign <= 1'b0;
      r_disp_bcd  <= 12'h000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_pend_full) begin
            r_sample    <= r_pend_val;
            r_pend_full <= 1'b0;
            r_state     <= S_LOAD;
            r_busy      <= 1'b1;
          end else if (temp_valid) begin
            r_sample <= temp_in;
            r_state  <= S_LOAD;
            r_busy   <= 1'b1;
          end
        end
        S_LOAD: begin
          r_sign  <= w_neg;
          r_mag   <= w_mag_load;
          r_bcd   <= 12'h000;
          r_iter  <= 3'd0;
          r_state <= S_CONV;
        end
        S_CONV: begin
          {r_bcd, r_mag} <= w_cat;
          r_iter         <= r_iter + 3'd1;
          if (r_iter == 3'd7)
            r_state <= S_UPDATE;
        end
        S_UPDATE: begin
          r_disp_sign <= r_sign;
          r_disp_bcd  <= r_bcd;
          if (r_pend_full) begin
            r_sample    <= r_pend_val;
            r_pend_full <= 1'b0;
            r_state     <= S_LOAD;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
      // A strobe that is not starting a conversion directly lands in pending;
      // it overrides any consume above, so the newest value always survives.
      if (temp_valid && ((r_state != S_IDLE) || r_pend_full)) begin
        r_pend_val  <= temp_in;
        r_pend_full <= 1'b1;
      end
    end
  end

  // Refresh divider and scan index, free-running and independent of the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div      <= 16'd0;
      r_scan_idx <= 2'd0;
    end else begin
      r_div      <= (r_div == DIV_LAST) ? 16'd0 : (r_div + 16'd1);
      r_scan_idx <= w_idx_next;
    end
  end

  // Segment and digit-enable output registers, updated together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg    <= SEG_RST;
      r_dig_en <= DIG_RST;
    end else begin
      r_seg    <= w_seg_next ^ SEG_MASK;
      r_dig_en <= (3'b001 << w_idx_next) ^ DIG_MASK;
    end
  end

  assign busy   = r_busy;
  assign seg    = r_seg;
  assign dig_en = r_dig_en;

endmodule

// File: tb/tb_lm07_temp_display_ctrl.sv
// Bench for lm07_temp_display_ctrl: directed and random samples checked
// against a decimal reference model of the display contents.

module tb_lm07_temp_display_ctrl;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] temp_in;
  logic       temp_valid;
  logic       busy;
  logic [7:0] seg;
  logic [2:0] dig_en;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lm07_temp_display_ctrl #(
    .REFRESH_DIV    (DIV),
    .SEG_ACTIVE_LOW (1'b0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .temp_in    (temp_in),
    .temp_valid (temp_valid),
    .busy       (busy),
    .seg        (seg),
    .dig_en     (dig_en)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] code7(input int d);
    case (d)
      0: return 8'h3F;
      1: return 8'h06;
      2: return 8'h5B;
      3: return 8'h4F;
      4: return 8'h66;
      5: return 8'h6D;
      6: return 8'h7D;
      7: return 8'h07;
      8: return 8'h7F;
      9: return 8'h6F;
      default: return 8'h00;
    endcase
  endfunction

  // Expected pattern of digit idx when the display shows temperature t.
  function automatic logic [7:0] exp_digit(input int t, input int idx);
    int mag, h, te, o;
    bit neg;
    neg = (t < 0);
    mag = neg ? -t : t;
    if (neg && mag > 99) mag = 99;
    h  = mag / 100;
    te = (mag / 10) % 10;
    o  = mag % 10;
    case (idx)
      2:       return neg ? 8'h40 : ((h != 0) ? code7(h) : 8'h00);
      1:       return (h == 0 && te == 0) ? 8'h00 : code7(te);
      default: return code7(o);
    endcase
  endfunction

  // One sample of the scanned bus against the model for value t.
  task automatic sample_digit(input string tag, input int t);
    int idx;
    case (dig_en)
      3'b001: idx = 0;
      3'b010: idx = 1;
      3'b100: idx = 2;
      default: begin
        idx = 0;
        chk("dig_onehot", {29'd0, dig_en}, 32'd1);
      end
    endcase
    chk(tag, {24'd0, seg}, {24'd0, exp_digit(t, idx)});
  endtask

  task automatic check_display(input string tag, input int t, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      sample_digit(tag, t);
      tick();
    end
  endtask

  // Single strobe from idle: busy timing then the decoded digits.
  task automatic run_conv(input logic [7:0] v);
    int t;
    t = $signed(v);
    temp_in    = v;
    temp_valid = 1'b1;
    tick();
    temp_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      chk("busy_conv", {31'd0, busy}, 32'd1);
      tick();
    end
    chk("busy_done", {31'd0, busy}, 32'd0);
    check_display("digit", t, 3 * DIV);
    $display("conv temp=%0d done checks=%0d errors=%0d", t, checks, errors);
  endtask

  initial begin
    rst_n      = 1'b0;
    temp_in    = 8'h00;
    temp_valid = 1'b0;
    repeat (3) tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_seg", {24'd0, seg}, 32'h3F);
    chk("rst_dig", {29'd0, dig_en}, 32'd1);
    $display("reset state checked");

    // Scan sequence straight after reset release.
    rst_n = 1'b1;
    for (int k = 0; k < 6 * DIV; k++) begin
      int idx;
      idx = (k / DIV) % 3;
      chk("scan_dig", {29'd0, dig_en}, 32'd1 << idx);
      chk("scan_seg", {24'd0, seg}, {24'd0, exp_digit(0, idx)});
      tick();
    end
    $display("scan sequence checked");

    // Directed values, including clamp and blanking boundaries.
    run_conv(8'd25);
    run_conv(8'hF9);
    run_conv(8'd127);
    run_conv(8'h80);
    run_conv(8'd0);
    run_conv(8'd100);
    run_conv(8'h9D);
    run_conv(8'h9C);

    // Random samples over the full signed range.
    for (int i = 0; i < 12; i++)
      run_conv(8'($urandom_range(0, 255)));

    // Three back-to-back strobes: 10 converts, 30 overwrites 20 in pending.
    temp_in    = 8'd10;
    temp_valid = 1'b1;
    tick();
    for (int c = 1; c <= 20; c++) begin
      if (c == 1) begin temp_in = 8'd20; temp_valid = 1'b1; end
      if (c == 2) begin temp_in = 8'd30; temp_valid = 1'b1; end
      if (c == 3) temp_valid = 1'b0;
      chk("busy_pend", {31'd0, busy}, 32'd1);
      if (c >= 11) sample_digit("pend_first", 10);
      tick();
    end
    chk("busy_pend_done", {31'd0, busy}, 32'd0);
    check_display("pend_last", 30, 3 * DIV);
    $display("pending sequence checked errors=%0d", errors);

    // Reset during a conversion with a pending value queued behind it.
    temp_in    = 8'd99;
    temp_valid = 1'b1;
    tick();
    temp_valid = 1'b0;
    repeat (3) tick();
    temp_in    = 8'd55;
    temp_valid = 1'b1;
    tick();
    temp_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_seg", {24'd0, seg}, 32'h3F);
    chk("midrst_dig", {29'd0, dig_en}, 32'd1);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4 * DIV; c++) begin
      chk("midrst_idle", {31'd0, busy}, 32'd0);
      sample_digit("midrst_disp", 0);
      tick();
    end
    $display("mid-conversion reset checked errors=%0d", errors);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
